// File: rtl/word_ser_pkg.sv
// Shared types and constants for the word-to-byte serializer and its byte lane mux.
package word_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int BYTES  = 4;

    typedef logic [1:0] len_t;

    // Ones in every bit above byte index len; such bits are dropped by the serializer.
    function automatic logic [BYTES*BYTE_W-1:0] above_len_mask(input len_t len);
        logic [BYTES*BYTE_W-1:0] ones;
        ones = '1;
        return ones << (BYTE_W * (int'(len) + 1));
    endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Combinational 32-to-8 byte lane select by 2-bit byte index; shared with load-byte logic.
module byte_lane_mux
    import word_ser_pkg::*;
(
    input  logic [BYTES*BYTE_W-1:0] word_i,
    input  len_t                    sel_i,
    output logic [BYTE_W-1:0]       byte_o
);

    always_comb begin
        byte_o = word_i[BYTE_W-1:0];
        case (sel_i)
            2'd0: byte_o = word_i[1*BYTE_W-1:0*BYTE_W];
            2'd1: byte_o = word_i[2*BYTE_W-1:1*BYTE_W];
            2'd2: byte_o = word_i[3*BYTE_W-1:2*BYTE_W];
            2'd3: byte_o = word_i[4*BYTE_W-1:3*BYTE_W];
            default: byte_o = word_i[BYTE_W-1:0];
        endcase
    end

endmodule

// File: rtl/word_byte_serializer.sv
// Serializes a 32-bit word into 1-4 bytes over a valid/ready byte stream.
// Define WORD_BYTE_SERIALIZER_TRUNC_CHECK_EN to add the sticky trunc_err output.
module word_byte_serializer
    import word_ser_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  len_t              in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
`ifdef WORD_BYTE_SERIALIZER_TRUNC_CHECK_EN
    output logic              trunc_err,
`endif
    output logic              busy
);

    if (WORD_W != BYTES * BYTE_W) begin : g_word_w_check
        $error("word_byte_serializer: WORD_W must be 32");
    end

    // Handshake semantics on both sides: a transfer happens on a rising clk edge
    // where valid & ready are both 1. A raised valid is held with its data stable
    // until that transfer; ready may change freely and carries no obligation.

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       hold_q, hold_d;
    len_t                    len_q, len_d;
    len_t                    cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [BYTE_W-1:0]       out_byte_q, out_byte_d;
    len_t                    sel_d;
    logic [BYTE_W-1:0]       lane_byte;
    logic                    take_last;
    logic                    accept;

    assign take_last = out_valid_q & out_ready & out_last_q;
    assign in_ready  = (state_q == IDLE) | take_last;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SEND;
            hold_d  = in_word;
            len_d   = in_len;
            cnt_d   = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_last_q) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // Outputs are registered, so the lane is chosen from the next-state hold/len/cnt.
    always_comb begin
        sel_d = BIG_ENDIAN ? len_t'(len_d - cnt_d) : cnt_d;
    end

    byte_lane_mux u_lane_mux (
        .word_i (hold_d),
        .sel_i  (sel_d),
        .byte_o (lane_byte)
    );

    always_comb begin
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (cnt_d == len_d);
        out_byte_d  = (state_d == SEND) ? lane_byte : out_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_byte  = out_byte_q;
    assign busy      = (state_q == SEND);

`ifdef WORD_BYTE_SERIALIZER_TRUNC_CHECK_EN
    logic trunc_err_q, trunc_err_d;

    always_comb begin
        trunc_err_d = trunc_err_q;
        if (accept && ((in_word & above_len_mask(in_len)) != '0)) begin
            trunc_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc_err_q <= 1'b0;
        end else begin
            trunc_err_q <= trunc_err_d;
        end
    end

    assign trunc_err = trunc_err_q;
`endif

endmodule
